pressure_abnormality_detector: RTL and testbench

PRESSURE_ABNORMALITY_DETECTOR -- requirements
Module: pressure_abnormality_detector

---
 rtl/pressure_abnormality_detector_if.sv | 34 +++
 rtl/pressure_abnormality_detector.sv | 78 +++++++
 tb/tb_pressure_abnormality_detector.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pressure_abnormality_detector_if.sv
// Sample/alarm bus for pressure_abnormality_detector.
// The producer drives the samples and alarmClear; the detector drives the status flags and count.
interface pressure_abnormality_detector_if;
  logic [5:0] pressureData;
  logic       sampleValid;
  logic       alarmClear;
  logic       presureAbnormality;
  logic       tooHigh;
  logic       tooLow;
  logic       alarmLatched;
  logic [7:0] abnormalCount;

  modport master (
    output pressureData,
    output sampleValid,
    output alarmClear,
    input  presureAbnormality,
    input  tooHigh,
    input  tooLow,
    input  alarmLatched,
    input  abnormalCount
  );

  modport slave (
    input  pressureData,
    input  sampleValid,
    input  alarmClear,
    output presureAbnormality,
    output tooHigh,
    output tooLow,
    output alarmLatched,
    output abnormalCount
  );
endinterface

// File: rtl/pressure_abnormality_detector.sv
// Registered range classifier for 6-bit pressure samples, with a sticky alarm on PERSIST
// consecutive abnormal samples and a saturating count of all abnormal samples.
module pressure_abnormality_detector #(
  parameter logic [5:0]  LOW_LIMIT  = 6'd8,
  parameter logic [5:0]  HIGH_LIMIT = 6'd40,
  parameter int unsigned PERSIST    = 3
) (
  input logic                                clk,
  input logic                                rst,
  pressure_abnormality_detector_if.slave     bus
);

  localparam logic [3:0] PersistMax = 4'(PERSIST);

  logic       too_high_q, too_high_d;
  logic       too_low_q, too_low_d;
  logic       alarm_q, alarm_d;
  logic [7:0] abn_cnt_q, abn_cnt_d;
  logic [3:0] persist_q, persist_d;

  logic is_high, is_low, is_abn;

  assign is_high = bus.pressureData > HIGH_LIMIT;
  assign is_low  = bus.pressureData < LOW_LIMIT;
  assign is_abn  = is_high | is_low;

  always_comb begin
    too_high_d = too_high_q;
    too_low_d  = too_low_q;
    alarm_d    = alarm_q;
    abn_cnt_d  = abn_cnt_q;
    persist_d  = persist_q;
    if (bus.sampleValid) begin
      too_high_d = is_high;
      too_low_d  = is_low;
      if (is_abn) begin
        if (abn_cnt_q != 8'hff) abn_cnt_d = abn_cnt_q + 8'd1;
        // Alarm sets on the edge that brings the run length to PERSIST.
        if (persist_q >= PersistMax - 4'd1) begin
          persist_d = PersistMax;
          alarm_d   = 1'b1;
        end else begin
          persist_d = persist_q + 4'd1;
        end
      end else begin
        persist_d = 4'd0;
      end
    end
    // Clear overrides any alarm/persistence update from a simultaneous sample.
    if (bus.alarmClear) begin
      alarm_d   = 1'b0;
      persist_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      too_high_q <= 1'b0;
      too_low_q  <= 1'b0;
      alarm_q    <= 1'b0;
      abn_cnt_q  <= 8'd0;
      persist_q  <= 4'd0;
    end else begin
      too_high_q <= too_high_d;
      too_low_q  <= too_low_d;
      alarm_q    <= alarm_d;
      abn_cnt_q  <= abn_cnt_d;
      persist_q  <= persist_d;
    end
  end

  assign bus.tooHigh            = too_high_q;
  assign bus.tooLow             = too_low_q;
  assign bus.presureAbnormality = too_high_q | too_low_q;
  assign bus.alarmLatched       = alarm_q;
  assign bus.abnormalCount      = abn_cnt_q;

endmodule

// File: tb/tb_pressure_abnormality_detector.sv
// Self-checking bench: table of stimulus/expected records fed through a scoreboard queue,
// plus hand-written hold, saturation and mid-run reset sequences.
module tb_pressure_abnormality_detector;

  typedef struct packed {
    logic       abn;
    logic       hi;
    logic       lo;
    logic       alarm;
    logic [7:0] cnt;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [5:0] data;
    logic       clr;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[$];

  pressure_abnormality_detector_if bus ();

  pressure_abnormality_detector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic a, logic h, logic l, logic al, int c);
    exp_t e;
    e.abn = a; e.hi = h; e.lo = l; e.alarm = al; e.cnt = 8'(c);
    return e;
  endfunction

  function automatic void add(logic r, logic v, int d, logic c, exp_t e);
    vec_t x;
    x.rst = r; x.valid = v; x.data = 6'(d); x.clr = c; x.e = e;
    vecs.push_back(x);
  endfunction

  task automatic check(string name);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if ({bus.presureAbnormality, bus.tooHigh, bus.tooLow, bus.alarmLatched,
         bus.abnormalCount} !== e) begin
      errors++;
      $display("FAIL %s: got abn=%0b hi=%0b lo=%0b alarm=%0b cnt=%0d want abn=%0b hi=%0b lo=%0b alarm=%0b cnt=%0d",
               name, bus.presureAbnormality, bus.tooHigh, bus.tooLow, bus.alarmLatched,
               bus.abnormalCount, e.abn, e.hi, e.lo, e.alarm, e.cnt);
    end
    checks++;
    if ((bus.tooHigh & bus.tooLow) !== 1'b0 ||
        bus.presureAbnormality !== (bus.tooHigh | bus.tooLow)) begin
      errors++;
      $display("FAIL %s_flags: got abn=%0b hi=%0b lo=%0b want hi&lo=0 abn=hi|lo",
               name, bus.presureAbnormality, bus.tooHigh, bus.tooLow);
    end
  endtask

  task automatic step(string name, logic r, logic v, logic [5:0] d, logic c, exp_t e);
    @(negedge clk);
    rst              = r;
    bus.sampleValid  = v;
    bus.pressureData = d;
    bus.alarmClear   = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    exp_t last;
    bus.sampleValid  = 1'b0;
    bus.pressureData = 6'd0;
    bus.alarmClear   = 1'b0;

    //  rst  v   data clr  expected {abn, hi, lo, alarm, cnt}
    add(1, 0,  0, 0, mk(0, 0, 0, 0, 0));
    add(0, 1, 40, 0, mk(0, 0, 0, 0, 0));
    add(0, 1, 44, 0, mk(1, 1, 0, 0, 1));
    add(0, 1,  0, 0, mk(1, 0, 1, 0, 2));
    add(0, 1, 20, 0, mk(0, 0, 0, 0, 2));
    add(0, 1, 63, 0, mk(1, 1, 0, 0, 3));
    add(0, 1, 63, 0, mk(1, 1, 0, 0, 4));
    add(0, 1, 63, 0, mk(1, 1, 0, 1, 5));
    add(0, 1, 20, 0, mk(0, 0, 0, 1, 5));
    add(0, 0, 20, 1, mk(0, 0, 0, 0, 5));
    add(0, 1, 50, 0, mk(1, 1, 0, 0, 6));
    add(0, 1, 50, 0, mk(1, 1, 0, 0, 7));
    add(0, 1, 20, 0, mk(0, 0, 0, 0, 7));
    add(0, 1, 50, 0, mk(1, 1, 0, 0, 8));
    add(0, 1, 50, 0, mk(1, 1, 0, 0, 9));
    add(0, 1,  8, 0, mk(0, 0, 0, 0, 9));
    add(0, 1, 40, 0, mk(0, 0, 0, 0, 9));
    add(0, 1,  7, 0, mk(1, 0, 1, 0, 10));
    add(0, 1, 41, 0, mk(1, 1, 0, 0, 11));
    add(0, 1, 41, 1, mk(1, 1, 0, 0, 12));
    add(0, 1, 41, 0, mk(1, 1, 0, 0, 13));
    add(0, 1, 41, 0, mk(1, 1, 0, 0, 14));
    add(1, 1, 41, 1, mk(0, 0, 0, 0, 0));
    add(0, 1, 41, 0, mk(1, 1, 0, 0, 1));
    add(0, 1, 41, 0, mk(1, 1, 0, 0, 2));
    add(0, 1, 41, 0, mk(1, 1, 0, 1, 3));
    add(0, 0, 63, 0, mk(1, 1, 0, 1, 3));
    add(0, 1, 20, 0, mk(0, 0, 0, 1, 3));
    add(0, 1, 63, 1, mk(1, 1, 0, 0, 4));
    add(0, 1, 63, 0, mk(1, 1, 0, 0, 5));
    add(0, 1, 63, 0, mk(1, 1, 0, 0, 6));
    add(0, 1, 63, 0, mk(1, 1, 0, 1, 7));

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].clr,
           vecs[i].e);
    end

    // Invalid samples of 63 must leave every output untouched.
    last = mk(1, 1, 0, 1, 7);
    for (int i = 0; i < 10; i++) step($sformatf("hold%0d", i), 0, 0, 6'd63, 0, last);

    // Saturation of the abnormal count.
    step("sat_rst", 1, 0, 6'd0, 0, mk(0, 0, 0, 0, 0));
    for (int i = 1; i <= 300; i++) begin
      step($sformatf("sat%0d", i), 0, 1, 6'd63, 0,
           mk(1, 1, 0, i >= 3, (i > 255) ? 255 : i));
    end

    // Reset in the middle of an abnormal run, then partial run must not alarm.
    step("midrun_rst", 1, 1, 6'd63, 0, mk(0, 0, 0, 0, 0));
    step("post_rst1", 0, 1, 6'd2, 0, mk(1, 0, 1, 0, 1));
    step("post_rst2", 0, 1, 6'd2, 0, mk(1, 0, 1, 0, 2));
    step("post_rst3", 0, 1, 6'd2, 0, mk(1, 0, 1, 1, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
